// File: rtl/tick_prescaler_if.sv
// tick_prescaler_if: control and status bundle between a tick_prescaler and its user.
interface tick_prescaler_if #(parameter int width = 8, parameter int burst_width = 4);
  logic Start;
  logic Stop;
  logic [1:0] Mode;
  logic [width-1:0] Divisor;
  logic [burst_width-1:0] BurstCount;
  logic ClockEnable;
  logic Busy;
  logic Done;
  logic [burst_width-1:0] TicksLeft;
  modport master(output Start, Stop, Mode, Divisor, BurstCount, input ClockEnable, Busy, Done, TicksLeft);
  modport slave(input Start, Stop, Mode, Divisor, BurstCount, output ClockEnable, Busy, Done, TicksLeft);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides GlobalClock into single-cycle ClockEnable ticks in free-run, one-shot or burst mode.
module tick_prescaler #(parameter int width = 8, parameter int burst_width = 4) (
  input logic GlobalClock,
  input logic clear,
  tick_prescaler_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [1:0] mode_q;
  logic [width-1:0] div_q, cnt, d_in;
  logic [burst_width-1:0] ticks;
  logic done, burst, free, tick;
  always_comb begin
    d_in = bus.Divisor == '0 ? width'(1) : bus.Divisor;
    burst = mode_q == 2'b10;
    free = mode_q == 2'b00;
    // an empty burst runs for one cycle without ever ticking, whatever the divisor
    tick = state == RUN && cnt == '0 && !(burst && ticks == '0);
  end
  always_ff @(posedge GlobalClock) begin
    if (clear) begin
      state <= IDLE;
      mode_q <= '0;
      div_q <= '0;
      cnt <= '0;
      ticks <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (bus.Start && !bus.Stop) begin
          state <= RUN;
          mode_q <= bus.Mode;
          div_q <= d_in;
          cnt <= d_in - 1'b1;
          ticks <= bus.Mode == 2'b10 ? bus.BurstCount : '0;
        end
      end else if (bus.Stop) begin
        state <= IDLE;
        cnt <= '0;
        ticks <= '0;
      end else if (burst && ticks == '0) begin
        state <= IDLE;
        done <= 1'b1;
      end else if (tick) begin
        cnt <= div_q - 1'b1;
        if (burst) begin
          ticks <= ticks - 1'b1;
          if (ticks == burst_width'(1)) begin
            state <= IDLE;
            done <= 1'b1;
          end
        end else if (!free) begin
          state <= IDLE;
          done <= 1'b1;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
  assign bus.ClockEnable = tick;
  assign bus.Busy = state == RUN;
  assign bus.Done = done;
  assign bus.TicksLeft = ticks;
endmodule

// File: tb/tb_tick_prescaler.sv
// tb_tick_prescaler: directed and random stimulus against a cycles-since-start reference model.
module tb_tick_prescaler;
  logic GlobalClock, clear;
  tick_prescaler_if bus();
  tick_prescaler dut(.GlobalClock(GlobalClock), .clear(clear), .bus(bus));
  initial begin
    GlobalClock = 1'b0;
    forever #5 GlobalClock = ~GlobalClock;
  end
  int checks = 0, errors = 0, cyc_no = 0;
  bit chk = 0;
  // model: a sequence is "cycle n since Start was accepted", ticking when n is a multiple of D
  bit m_busy = 0, m_done = 0;
  int m_n = 0, m_d = 1, m_lim = 0, m_len = 0, m_bc = 0;
  logic [1:0] m_md = 0;
  task automatic cyc(input logic st, input logic sp, input logic cl, input logic [1:0] md, input logic [7:0] dv, input logic [3:0] b);
    logic e_ce, e_busy, e_done;
    logic [3:0] e_tl;
    if (chk) begin
      e_ce = m_busy && (m_n % m_d == 0) && m_lim != 0;
      e_busy = m_busy;
      e_done = m_done;
      e_tl = (m_busy && m_md == 2'b10) ? 4'(m_bc - (m_n - 1) / m_d) : 4'd0;
      checks += 4;
      assert (bus.ClockEnable === e_ce) else begin errors++; $error("FAIL ce cyc=%0d got %b exp %b", cyc_no, bus.ClockEnable, e_ce); end
      assert (bus.Busy === e_busy) else begin errors++; $error("FAIL busy cyc=%0d got %b exp %b", cyc_no, bus.Busy, e_busy); end
      assert (bus.Done === e_done) else begin errors++; $error("FAIL done cyc=%0d got %b exp %b", cyc_no, bus.Done, e_done); end
      assert (bus.TicksLeft === e_tl) else begin errors++; $error("FAIL ticks_left cyc=%0d got %0d exp %0d", cyc_no, bus.TicksLeft, e_tl); end
    end
    bus.Start = st;
    bus.Stop = sp;
    clear = cl;
    bus.Mode = md;
    bus.Divisor = dv;
    bus.BurstCount = b;
    if (cl) begin
      m_busy = 0;
      m_done = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (st && !sp) begin
        m_busy = 1;
        m_n = 1;
        m_d = dv == 0 ? 1 : int'(dv);
        m_md = md;
        m_bc = int'(b);
        m_lim = md == 2'b00 ? -1 : md == 2'b10 ? int'(b) : 1;
        m_len = m_lim == 0 ? 1 : m_lim * m_d;
      end
    end else if (sp) begin
      m_busy = 0;
      m_done = 0;
    end else if (m_lim >= 0 && m_n == m_len) begin
      m_busy = 0;
      m_done = 1;
    end else begin
      m_n++;
    end
    @(posedge GlobalClock);
    #1;
    cyc_no++;
    chk = 1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 2'($urandom), 8'($urandom), 4'($urandom));
  endtask
  initial begin
    bus.Start = 0; bus.Stop = 0; clear = 1; bus.Mode = 0; bus.Divisor = 0; bus.BurstCount = 0;
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    idle(2);
    cyc(1, 0, 0, 2'b00, 8'd4, 4'd0);
    for (int i = 0; i < 14; i++) cyc(1'($urandom), 1'b0, 1'b0, 2'($urandom), 8'($urandom), 4'($urandom));
    cyc(0, 1, 0, 0, 0, 0);
    idle(3);
    cyc(1, 0, 0, 2'b10, 8'd3, 4'd2);
    idle(8);
    cyc(1, 0, 0, 2'b01, 8'd0, 4'd0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 2'b01, 8'd0, 4'd0);
    idle(2);
    cyc(1, 0, 0, 2'b00, 8'd5, 4'd0);
    idle(4);
    cyc(0, 1, 0, 0, 0, 0);
    idle(7);
    cyc(1, 0, 0, 2'b10, 8'd1, 4'd0);
    idle(3);
    cyc(1, 0, 0, 2'b10, 8'd2, 4'd5);
    idle(3);
    cyc(1, 1, 1, 2'b10, 8'd2, 4'd5);
    idle(4);
    cyc(1, 1, 0, 2'b00, 8'd1, 4'd0);
    idle(2);
    cyc(1, 0, 0, 2'b11, 8'd3, 4'd7);
    idle(5);
    cyc(1, 0, 0, 2'b10, 8'd255, 4'd15);
    idle(10);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 127) == 0),
          2'($urandom), 8'($urandom_range(0, 6)), 4'($urandom_range(0, 4)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
